feat_frame_assembler: RTL and testbench

- Upstream stage of the classifier datapath.
- Accepts raw sensor channel samples one per handshake.
- Subtracts a per-channel baseline with signed saturation, then assembles a complete DIMS-element feature vector.
- Presents the vector on a held valid/ready output that drives the classifier's din input; one capture buffer plus one output register lets the next frame fill while the current vector is held.

---
 rtl/feat_frame_if.sv | 24 ++
 rtl/feat_frame_assembler.sv | 110 +++++++++++
 tb/tb_feat_frame_assembler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/feat_frame_if.sv
// Handshake bundle between the raw-sample source, the frame assembler and the
// classifier input: sample stream in, held feature vector out.
interface feat_frame_if #(
  parameter int DIMS = 21,
  parameter int W    = 16
);
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_data;
  logic                s_first;
  logic signed [W-1:0] vec [DIMS];
  logic                vec_valid;
  logic                vec_ready;

  modport master (
    output s_valid, s_data, s_first, vec_ready,
    input  s_ready, vec, vec_valid
  );

  modport slave (
    input  s_valid, s_data, s_first, vec_ready,
    output s_ready, vec, vec_valid
  );
endinterface

// File: rtl/feat_frame_assembler.sv
// Baseline-subtracts raw channel samples with signed saturation and assembles
// them into a DIMS-element feature vector held on a valid/ready output slot.
module feat_frame_assembler #(
  parameter int DIMS = 21,
  parameter int W    = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [W-1:0]        s_data_i,
  input  logic                s_first_i,
  input  logic [W-1:0]        baseline_i [DIMS],
  output logic signed [W-1:0] vec_o [DIMS],
  output logic                vec_valid_o,
  input  logic                vec_ready_i,
  output logic                frame_err_o,
  input  logic                clr_err_i
);

  localparam int IW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic signed [W-1:0] cap_buf [DIMS];

  logic                accept;
  logic                slot_free;
  logic [IW-1:0]       wr_idx;
  logic signed [W:0]   diff;
  logic signed [W-1:0] elem;

  assign s_ready_o = (state != PEND);

  // A first-flagged sample always lands in channel 0, including on a restart.
  always_comb begin
    accept    = s_valid_i & s_ready_o;
    slot_free = ~vec_valid_o | vec_ready_i;
    wr_idx    = s_first_i ? '0 : idx;
    diff      = $signed({1'b0, s_data_i}) - $signed({1'b0, baseline_i[wr_idx]});
    elem      = diff[W-1:0];
    if (diff[W] != diff[W-1]) begin
      elem = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      idx         <= '0;
      vec_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      for (int unsigned i = 0; i < DIMS; i++) begin
        vec_o[IW'(i)]   <= '0;
        cap_buf[IW'(i)] <= '0;
      end
    end else begin
      // Clear first so a same-edge restart below wins.
      if (clr_err_i) frame_err_o <= 1'b0;
      if (vec_valid_o && vec_ready_i) vec_valid_o <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept && s_first_i) begin
            cap_buf[0] <= elem;
            if (DIMS == 1) begin
              state <= PEND;
              idx   <= '0;
            end else begin
              state <= FILL;
              idx   <= IW'(1);
            end
          end
        end
        FILL: begin
          if (accept) begin
            cap_buf[wr_idx] <= elem;
            if (s_first_i) begin
              frame_err_o <= 1'b1;
              idx         <= IW'(1);
            end else if (idx == LAST) begin
              state <= PEND;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        PEND: begin
          if (slot_free) begin
            for (int unsigned i = 0; i < DIMS; i++) begin
              vec_o[IW'(i)] <= cap_buf[IW'(i)];
            end
            vec_valid_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feat_frame_assembler.sv
// Directed-sequence bench with randomized frame contents for feat_frame_assembler,
// checked against a plain-arithmetic saturating-difference model.
module tb_feat_frame_assembler;
  localparam int DIMS = 21;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_err;
  logic clr_err = 1'b0;
  logic [W-1:0] baseline [DIMS];

  feat_frame_if #(.DIMS(DIMS), .W(W)) ffi ();

  feat_frame_assembler #(.DIMS(DIMS), .W(W)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .s_valid_i   (ffi.s_valid),
    .s_ready_o   (ffi.s_ready),
    .s_data_i    (ffi.s_data),
    .s_first_i   (ffi.s_first),
    .baseline_i  (baseline),
    .vec_o       (ffi.vec),
    .vec_valid_o (ffi.vec_valid),
    .vec_ready_i (ffi.vec_ready),
    .frame_err_o (frame_err),
    .clr_err_i   (clr_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] fdata    [DIMS];
  logic [W-1:0] fexp     [DIMS];
  logic [W-1:0] hold_exp [DIMS];
  logic [W-1:0] zeros    [DIMS];

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] b);
    int v;
    v = int'(d) - int'(b);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return W'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] e [DIMS]);
    for (int k = 0; k < DIMS; k++)
      chk($sformatf("%s[%0d]", tag, k), {16'h0, ffi.vec[k]}, {16'h0, e[k]});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic f);
    int n = 0;
    while (ffi.s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", {31'h0, ffi.s_ready}, 32'h1);
    ffi.s_valid = 1'b1;
    ffi.s_data  = d;
    ffi.s_first = f;
    @(negedge clk);
    ffi.s_valid = 1'b0;
    ffi.s_first = 1'b0;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < DIMS; k++) begin
      fdata[k] = W'($urandom_range(0, 65535));
      fexp[k]  = model(fdata[k], baseline[k]);
    end
  endtask

  task automatic send_frame();
    for (int k = 0; k < DIMS; k++) send(fdata[k], (k == 0));
  endtask

  // Expects vec_ready=1: vector visible one edge after the last accept, for one cycle.
  task automatic frame_tail(input string tag);
    chk({tag, "_pre_valid"}, {31'h0, ffi.vec_valid}, 32'h0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, ffi.vec_valid}, 32'h1);
    check_vec(tag, fexp);
    @(negedge clk);
    chk({tag, "_drop"}, {31'h0, ffi.vec_valid}, 32'h0);
  endtask

  initial begin
    ffi.s_valid = 1'b0;
    ffi.s_data = '0;
    ffi.s_first = 1'b0;
    ffi.vec_ready = 1'b1;
    for (int k = 0; k < DIMS; k++) begin
      baseline[k] = 16'd100;
      zeros[k] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, ffi.vec_valid}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    check_vec("rst_vec", zeros);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, ffi.s_ready}, 32'h1);

    // Nominal ramp: expected vec[k] = k
    for (int k = 0; k < DIMS; k++) begin
      fdata[k] = W'(100 + k);
      fexp[k]  = W'(k);
    end
    send_frame();
    frame_tail("nominal");

    // Saturation and sign
    for (int k = 0; k < DIMS; k++) baseline[k] = W'($urandom_range(0, 65535));
    baseline[0] = 16'd0;     baseline[1] = 16'hFFFF; baseline[2] = 16'd20;
    rand_frame();
    fdata[0] = 16'hFFFF;     fdata[1] = 16'd0;       fdata[2] = 16'd10;
    for (int k = 0; k < DIMS; k++) fexp[k] = model(fdata[k], baseline[k]);
    send_frame();
    chk("sat_pos", {16'h0, fexp[0]}, 32'h7FFF);
    chk("sat_neg", {16'h0, fexp[1]}, 32'h8000);
    chk("neg10",   {16'h0, fexp[2]}, 32'hFFF6);
    frame_tail("sat");

    // Random frames with fresh baselines
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DIMS; k++) baseline[k] = W'($urandom_range(0, 65535));
      rand_frame();
      send_frame();
      frame_tail($sformatf("rand%0d", r));
    end

    // Backpressure: frame B fills while A is held
    ffi.vec_ready = 1'b0;
    rand_frame();
    hold_exp = fexp;
    send_frame();
    @(negedge clk);
    chk("bp_a_valid", {31'h0, ffi.vec_valid}, 32'h1);
    check_vec("bp_a", hold_exp);
    rand_frame();
    send_frame();
    chk("bp_ready_low", {31'h0, ffi.s_ready}, 32'h0);
    chk("bp_hold_valid", {31'h0, ffi.vec_valid}, 32'h1);
    check_vec("bp_hold", hold_exp);
    repeat (3) @(negedge clk);
    chk("bp_ready_still_low", {31'h0, ffi.s_ready}, 32'h0);
    check_vec("bp_hold_late", hold_exp);
    ffi.vec_ready = 1'b1;
    @(negedge clk);
    chk("bp_b2b_valid", {31'h0, ffi.vec_valid}, 32'h1);
    check_vec("bp_b", fexp);
    chk("bp_ready_back", {31'h0, ffi.s_ready}, 32'h1);
    @(negedge clk);
    chk("bp_drop", {31'h0, ffi.vec_valid}, 32'h0);

    // Resync: stray non-first samples in IDLE are dropped
    for (int k = 0; k < 5; k++) send(W'($urandom_range(0, 65535)), 1'b0);
    @(negedge clk);
    chk("drop_valid", {31'h0, ffi.vec_valid}, 32'h0);
    chk("drop_err", {31'h0, frame_err}, 32'h0);

    // Restart at idx 7, then a complete frame
    for (int k = 0; k < 7; k++) send(W'($urandom_range(0, 65535)), (k == 0));
    chk("partial_err", {31'h0, frame_err}, 32'h0);
    rand_frame();
    send(fdata[0], 1'b1);
    chk("restart_err", {31'h0, frame_err}, 32'h1);
    for (int k = 1; k < DIMS; k++) send(fdata[k], 1'b0);
    frame_tail("resync");

    // Clear coinciding with a restart: set wins
    for (int k = 0; k < 3; k++) send(W'($urandom_range(0, 65535)), (k == 0));
    rand_frame();
    clr_err = 1'b1;
    send(fdata[0], 1'b1);
    clr_err = 1'b0;
    chk("set_over_clr", {31'h0, frame_err}, 32'h1);
    for (int k = 1; k < DIMS; k++) send(fdata[k], 1'b0);
    frame_tail("resync2");
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err", {31'h0, frame_err}, 32'h0);

    // Reset mid-frame at idx 12 (vec_o holds a nonzero vector here)
    rand_frame();
    for (int k = 0; k < 12; k++) send(fdata[k], (k == 0));
    rstn = 1'b0;
    #1;
    chk("rst12_valid", {31'h0, ffi.vec_valid}, 32'h0);
    check_vec("rst12_vec", zeros);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 12; k < DIMS; k++) send(fdata[k], 1'b0);
    @(negedge clk);
    chk("rst12_no_out", {31'h0, ffi.vec_valid}, 32'h0);
    rand_frame();
    send_frame();
    frame_tail("after_rst12");

    // Reset while a vector is pending behind a held one
    ffi.vec_ready = 1'b0;
    rand_frame();
    send_frame();
    @(negedge clk);
    chk("rstp_x_valid", {31'h0, ffi.vec_valid}, 32'h1);
    rand_frame();
    send_frame();
    chk("rstp_pend", {31'h0, ffi.s_ready}, 32'h0);
    rstn = 1'b0;
    #1;
    chk("rstp_valid", {31'h0, ffi.vec_valid}, 32'h0);
    chk("rstp_ready", {31'h0, ffi.s_ready}, 32'h1);
    check_vec("rstp_vec", zeros);
    @(negedge clk);
    rstn = 1'b1;
    ffi.vec_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstp_no_out", {31'h0, ffi.vec_valid}, 32'h0);
    rand_frame();
    send_frame();
    frame_tail("after_rstp");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
